// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl
// Sits between the RX gearbox and the block-lock FSM of a 10GBASE-R PCS
// receive path. It forwards sync headers to the lock FSM and turns lock-FSM
// slip requests into single gearbox slip pulses. After each slip it blanks
// headers for a holdoff window while the gearbox settles, and it tracks the
// current bit offset. If a full sweep of every offset gives no lock, it
// restarts the lock FSM.
//
// Ports
//   i_clk, i_reset_n     clock; asynchronous active-low reset
//   i_hdr_valid, i_hdr   header strobe and header from the gearbox
//   i_slip               slip request from the lock FSM (1-cycle pulse)
//   i_block_lock         block_lock level from the lock FSM
//   o_hdr_valid, o_hdr   gated, registered header path to the lock FSM
//   o_gb_slip            1-cycle slip pulse to the gearbox
//   o_bit_offset         current alignment offset, 0..NUM_OFFSETS-1
//   o_lock_restart       1-cycle pulse on FAIL entry: lock FSM back to RESET_CNT
//   o_align_fail         high while in FAIL
//   o_slip_total         lifetime slip count, saturating at 16'hFFFF
//
// Build option: define RX_SYNC_CTRL_STATS_EN to include the slip counter.
// Without it, o_slip_total is tied to 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// SEARCH  | forwarding headers, waiting for a slip request or for lock
// HOLDOFF | after a slip; the next SLIP_HOLDOFF header beats are dropped
// LOCKED  | lock FSM reports block_lock; headers forwarded
// FAIL    | full sweep gave no lock; headers blocked for FAIL_WAIT cycles

module rx_sync_ctrl #(
    parameter int HDR_WIDTH    = 2,
    parameter int NUM_OFFSETS  = 66,
    parameter int SLIP_HOLDOFF = 4,
    parameter int FAIL_WAIT    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_hdr_valid,
    input  logic [HDR_WIDTH-1:0] i_hdr,
    input  logic                 i_slip,
    input  logic                 i_block_lock,
    output logic                 o_hdr_valid,
    output logic [HDR_WIDTH-1:0] o_hdr,
    output logic                 o_gb_slip,
    output logic [6:0]           o_bit_offset,
    output logic                 o_lock_restart,
    output logic                 o_align_fail,
    output logic [15:0]          o_slip_total
);

    localparam int HOLD_W = $clog2(SLIP_HOLDOFF + 1);
    localparam int FAIL_W = $clog2(FAIL_WAIT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(SLIP_HOLDOFF);
    localparam logic [FAIL_W-1:0] FAIL_LOAD  = FAIL_W'(FAIL_WAIT);
    localparam logic [6:0]        OFF_LAST   = 7'(NUM_OFFSETS - 1);
    localparam logic [6:0]        SWEEP_FULL = 7'(NUM_OFFSETS);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        HOLDOFF = 2'd1,
        LOCKED  = 2'd2,
        FAIL    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [6:0]          sweep;
    logic [6:0]          sweep_nxt;
    logic [6:0]          offset_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [FAIL_W-1:0]   fail_nxt;
    logic                fwd;
    logic                slip_fire;
    logic                restart_fire;

    always_comb begin
        state_nxt    = state;
        sweep_nxt    = sweep;
        offset_nxt   = o_bit_offset;
        hold_nxt     = hold_cnt;
        fail_nxt     = fail_cnt;
        fwd          = 1'b0;
        slip_fire    = 1'b0;
        restart_fire = 1'b0;

        case (state)
            SEARCH: begin
                fwd = 1'b1;
                // A slip request wins over a simultaneous lock indication.
                if (i_slip) begin
                    slip_fire = 1'b1;
                    sweep_nxt = sweep + 7'd1;
                end else if (i_block_lock) begin
                    state_nxt = LOCKED;
                    sweep_nxt = '0;
                end
            end
            LOCKED: begin
                fwd = 1'b1;
                // Losing lock through a slip starts a fresh sweep at 1.
                if (i_slip) begin
                    slip_fire = 1'b1;
                    sweep_nxt = 7'd1;
                end else if (!i_block_lock) begin
                    state_nxt = SEARCH;
                    sweep_nxt = '0;
                end
            end
            HOLDOFF: begin
                // Counted in header beats; idle cycles stretch the window.
                if (i_hdr_valid) begin
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state_nxt = SEARCH;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt - HOLD_W'(1);
                    end
                end
            end
            FAIL: begin
                if (fail_cnt <= FAIL_W'(1)) begin
                    state_nxt = SEARCH;
                    sweep_nxt = '0;
                    fail_nxt  = '0;
                end else begin
                    fail_nxt = fail_cnt - FAIL_W'(1);
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase

        if (slip_fire) begin
            offset_nxt = (o_bit_offset == OFF_LAST) ? 7'd0 : o_bit_offset + 7'd1;
            if (sweep_nxt == SWEEP_FULL) begin
                state_nxt    = FAIL;
                fail_nxt     = FAIL_LOAD;
                restart_fire = 1'b1;
            end else begin
                state_nxt = HOLDOFF;
                hold_nxt  = HOLD_LOAD;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= SEARCH;
            sweep          <= '0;
            hold_cnt       <= '0;
            fail_cnt       <= '0;
            o_hdr_valid    <= 1'b0;
            o_hdr          <= '0;
            o_gb_slip      <= 1'b0;
            o_bit_offset   <= '0;
            o_lock_restart <= 1'b0;
            o_align_fail   <= 1'b0;
        end else begin
            state          <= state_nxt;
            sweep          <= sweep_nxt;
            hold_cnt       <= hold_nxt;
            fail_cnt       <= fail_nxt;
            o_hdr_valid    <= fwd && i_hdr_valid;
            if (fwd && i_hdr_valid) begin
                o_hdr <= i_hdr;
            end
            o_gb_slip      <= slip_fire;
            o_bit_offset   <= offset_nxt;
            o_lock_restart <= restart_fire;
            o_align_fail   <= (state_nxt == FAIL);
        end
    end

`ifdef RX_SYNC_CTRL_STATS_EN
    logic [15:0] slip_total;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            slip_total <= '0;
        end else if (slip_fire && (slip_total != 16'hFFFF)) begin
            slip_total <= slip_total + 16'd1;
        end
    end

    assign o_slip_total = slip_total;
`else
    assign o_slip_total = '0;
`endif

endmodule
